// File: rtl/cache_ctrl.sv
// cache_ctrl: blocking cache controller between a CPU pipeline, a cache array and memory.
// Latency: read hit 0 cycles (combinational); read miss = memory ack cycles + 3 to stall release.
// Backpressure: stall freezes the CPU; memory handshake is req held until a one-cycle ack.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-low reset
//   cpu_rd/cpu_wr/cpu_addr/cpu_wdata   CPU load/store request (store wins if both set)
//   cpu_rdata, stall              load result and pipeline freeze
//   c_hit, c_rdata, c_raddr       cache lookup (c_raddr follows cpu_addr combinationally)
//   c_waddr, c_wdata, c_dwe       cache fill port, one-cycle write strobe
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack   memory request/ack handshake
//
// Build option: define CACHE_CTRL_WBUF_EN to add a one-entry posted write buffer so that
// stores into an empty buffer do not stall the CPU.

module cache_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  input  logic              c_hit,
  input  logic [DATA_W-1:0] c_rdata,
  output logic [ADDR_W-1:0] c_raddr,
  output logic [ADDR_W-1:0] c_waddr,
  output logic [DATA_W-1:0] c_wdata,
  output logic              c_dwe,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    FILL   = 3'd2,
    RESP   = 3'd3,
    WR_REQ = 3'd4
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_c_dwe;
  logic [ADDR_W-1:0] r_c_waddr;
  logic [DATA_W-1:0] r_c_wdata;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic w_idle;
  logic w_store;
  logic w_load;
  logic w_hit;
  logic w_miss;
  logic w_store_go;
  logic w_miss_go;
  logic w_stall;

  // Request decode only happens in IDLE; a store masks a simultaneous load.
  assign w_idle  = (r_state == IDLE);
  assign w_store = rst && w_idle && cpu_wr;
  assign w_load  = rst && w_idle && cpu_rd && !cpu_wr;
  assign w_hit   = w_load && c_hit;
  assign w_miss  = w_load && !c_hit;

`ifdef CACHE_CTRL_WBUF_EN
  // Buffer entry is the in-flight memory write; it owns the memory port until acked.
  logic r_wb_vld;

  // A miss must not overtake a buffered write, so it waits in IDLE (stalled) until drain.
  assign w_store_go = w_store && !r_wb_vld;
  assign w_miss_go  = w_miss && !r_wb_vld;
  assign w_stall    = (w_store && r_wb_vld) || w_miss ||
                      (r_state == RD_REQ) || (r_state == FILL);
`else
  assign w_store_go = w_store;
  assign w_miss_go  = w_miss;
  // Stall drops in the ack cycle itself so the CPU retires the store on that edge
  // and does not present it again when the FSM is back in IDLE.
  assign w_stall    = w_store || w_miss ||
                      (r_state == RD_REQ) || (r_state == FILL) ||
                      ((r_state == WR_REQ) && !mem_ack);
`endif

  assign stall     = rst && w_stall;
  assign cpu_rdata = w_hit ? c_rdata : r_cpu_rdata;
  assign c_raddr   = cpu_addr;
  assign c_waddr   = r_c_waddr;
  assign c_wdata   = r_c_wdata;
  assign c_dwe     = r_c_dwe;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cpu_rdata <= '0;
      r_c_dwe     <= 1'b0;
      r_c_waddr   <= '0;
      r_c_wdata   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
`ifdef CACHE_CTRL_WBUF_EN
      r_wb_vld    <= 1'b0;
`endif
    end else begin
      // Fill strobe is a single-cycle pulse unless re-armed below.
      r_c_dwe <= 1'b0;
`ifdef CACHE_CTRL_WBUF_EN
      if (r_wb_vld && mem_ack) begin
        r_wb_vld  <= 1'b0;
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
      end
`endif
      case (r_state)
        IDLE: begin
          if (w_store_go) begin
            // Write-allocate/write-through: cache fill and memory write start together.
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= cpu_addr;
            r_mem_wdata <= cpu_wdata;
            r_c_dwe     <= 1'b1;
            r_c_waddr   <= cpu_addr;
            r_c_wdata   <= cpu_wdata;
`ifdef CACHE_CTRL_WBUF_EN
            r_wb_vld    <= 1'b1;
`else
            r_state     <= WR_REQ;
`endif
          end else if (w_miss_go) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= cpu_addr;
            r_state    <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (mem_ack) begin
            // r_c_wdata doubles as the registered miss data for the RESP cycle.
            r_mem_req <= 1'b0;
            r_c_dwe   <= 1'b1;
            r_c_waddr <= r_mem_addr;
            r_c_wdata <= mem_rdata;
            r_state   <= FILL;
          end
        end
        FILL: begin
          r_cpu_rdata <= r_c_wdata;
          r_state     <= RESP;
        end
        RESP: begin
          r_state <= IDLE;
        end
        WR_REQ: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed stimulus with a queue-based scoreboard for cache_ctrl.
// Stimulus pushes expected CPU completions, cache fills and memory transactions;
// a monitor pops and compares them whenever the DUT presents the matching event.

module tb_cache_ctrl;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int CYC_LIMIT = 5000;

  typedef struct {
    bit          st;
    int          cyc;
    logic [DW-1:0] dat;
  } resp_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } dwe_t;

  typedef struct {
    bit          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } mem_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_rd = 1'b0;
  logic          cpu_wr = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          stall;
  logic          c_hit = 1'b0;
  logic [DW-1:0] c_rdata = '0;
  logic [AW-1:0] c_raddr;
  logic [AW-1:0] c_waddr;
  logic [DW-1:0] c_wdata;
  logic          c_dwe;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  int  cyc = 0;
  int  ack_dly = 2;
  bit  force_ack = 1'b0;
  int  to_cnt = 0;
  bit  done = 1'b0;
  int  n_vec = 0;
  int  n_err = 0;

  resp_t resp_q[$];
  dwe_t  dwe_q[$];
  mem_t  mem_q[$];

  cache_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .stall(stall),
    .c_hit(c_hit), .c_rdata(c_rdata), .c_raddr(c_raddr), .c_waddr(c_waddr),
    .c_wdata(c_wdata), .c_dwe(c_dwe),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: ack arrives ack_dly cycles after the first mem_req cycle.
  initial begin
    int  cnt;
    bit  auto_ack;
    cnt = 0;
    auto_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_ack || !mem_req) begin
        cnt = 0;
        auto_ack = 1'b0;
      end else begin
        cnt++;
        auto_ack = (cnt == ack_dly + 1);
      end
      mem_ack = auto_ack || force_ack;
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) next();
  endtask

  // Drive one request and push everything the DUT is expected to produce for it.
  task automatic issue(input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input bit hit, input logic [DW-1:0] crd,
                       input logic [DW-1:0] mrd, input int dly, input int lat,
                       input logic [DW-1:0] exp_rd);
    resp_t r;
    dwe_t  f;
    mem_t  m;
    ack_dly   = dly;
    mem_rdata = mrd;
    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_addr  = a;
    cpu_wdata = wd;
    c_hit     = hit;
    c_rdata   = crd;
    r.st  = wr;
    r.cyc = cyc + lat;
    r.dat = exp_rd;
    resp_q.push_back(r);
    if (wr) begin
      f.a = a; f.d = wd;
      m.we = 1'b1; m.a = a; m.d = wd;
      dwe_q.push_back(f);
      mem_q.push_back(m);
    end else if (!hit) begin
      f.a = a; f.d = mrd;
      m.we = 1'b0; m.a = a; m.d = '0;
      dwe_q.push_back(f);
      mem_q.push_back(m);
    end
  endtask

  // Hold the request until stall is low, then retire it on the next edge.
  task automatic finish_req();
    int n;
    n = 0;
    @(negedge clk);
    while (stall && n < 60) begin
      next();
      @(negedge clk);
      n++;
    end
    if (stall) to_cnt++;
    next();
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  // Stimulus
  initial begin
    idle(3);
    rst = 1'b1;
    idle(2);

    // read hit, zero latency
    issue(1, 0, 8'h14, 16'h0000, 1, 16'hBEEF, 16'h0000, 2, 0, 16'hBEEF);
    finish_req();
    // read miss, ack 4 cycles after req -> released 7 cycles after request
    issue(1, 0, 8'h21, 16'h0000, 0, 16'h0000, 16'h1234, 4, 7, 16'h1234);
    finish_req();
    // read miss with immediate ack
    issue(1, 0, 8'h7F, 16'h0000, 0, 16'h0000, 16'hCAFE, 0, 3, 16'hCAFE);
    finish_req();
    // read hit at address 0
    issue(1, 0, 8'h00, 16'h0000, 1, 16'h0001, 16'h0000, 2, 0, 16'h0001);
    finish_req();
    idle(2);

`ifdef CACHE_CTRL_WBUF_EN
    // posted store: no stall
    issue(0, 1, 8'h08, 16'h00FF, 0, 16'h0000, 16'h0000, 2, 0, 16'h0000);
    finish_req();
    idle(8);
    // store then read miss next cycle: read waits for the write ack
    issue(0, 1, 8'h40, 16'h1111, 0, 16'h0000, 16'h0000, 3, 0, 16'h0000);
    finish_req();
    issue(1, 0, 8'h30, 16'h0000, 0, 16'h0000, 16'h5678, 3, 10, 16'h5678);
    finish_req();
    idle(8);
    // load and store together: store wins
    issue(1, 1, 8'h05, 16'hA5A5, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000);
    finish_req();
    idle(8);
`else
    // store, ack after 2 cycles -> stall until the ack cycle
    issue(0, 1, 8'h08, 16'h00FF, 0, 16'h0000, 16'h0000, 2, 3, 16'h0000);
    finish_req();
    // store with immediate ack
    issue(0, 1, 8'hFF, 16'hFFFF, 0, 16'h0000, 16'h0000, 0, 1, 16'h0000);
    finish_req();
    // load and store together: store wins
    issue(1, 1, 8'h05, 16'hA5A5, 0, 16'h0000, 16'h0000, 1, 2, 16'h0000);
    finish_req();
    idle(2);
`endif

    // reset while RD_REQ waits for ack, then a late ack must be ignored
    ack_dly  = 30;
    cpu_rd   = 1'b1;
    cpu_addr = 8'h50;
    c_hit    = 1'b0;
    next();
    next();
    rst    = 1'b0;
    cpu_rd = 1'b0;
    idle(2);
    rst = 1'b1;
    next();
    mem_rdata = 16'hDEAD;
    force_ack = 1'b1;
    next();
    force_ack = 1'b0;
    idle(3);

    // recovery after reset
    issue(1, 0, 8'h14, 16'h0000, 1, 16'h0BAD, 16'h0000, 2, 0, 16'h0BAD);
    finish_req();
    idle(4);
    done = 1'b1;
  end

  // Monitor / scoreboard: sole owner of n_vec and n_err.
  initial begin
    resp_t e;
    dwe_t  f;
    mem_t  m;
    bit    prev_rst;
    bit    prev_dwe;
    prev_rst = 1'b1;
    prev_dwe = 1'b0;
    while (!done && cyc < CYC_LIMIT) begin
      @(negedge clk);
      // rst low at the previous negedge means the last edge was a reset edge
      if (!prev_rst && !rst) begin
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_c_dwe", 32'(c_dwe), 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        chk("rst_c_wdata", 32'(c_wdata), 32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_c_waddr", 32'(c_waddr), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
      end
      if (rst && (cpu_rd || cpu_wr) && !stall) begin
        if (resp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexp_resp: got completion at cycle %0d, expected none", cyc);
        end else begin
          e = resp_q.pop_front();
          chk("resp_kind", 32'(cpu_wr), 32'(e.st));
          chk("resp_cycle", 32'(cyc), 32'(e.cyc));
          chk("c_raddr", 32'(c_raddr), 32'(cpu_addr));
          if (!e.st) chk("cpu_rdata", 32'(cpu_rdata), 32'(e.dat));
        end
      end
      if (c_dwe) begin
        chk("dwe_gap", 32'(prev_dwe), 32'h0);
        if (dwe_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexp_dwe: got fill addr %h data %h, expected none", c_waddr, c_wdata);
        end else begin
          f = dwe_q.pop_front();
          chk("c_waddr", 32'(c_waddr), 32'(f.a));
          chk("c_wdata", 32'(c_wdata), 32'(f.d));
        end
      end
      if (mem_req && mem_ack) begin
        if (mem_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexp_mem: got we %b addr %h, expected none", mem_we, mem_addr);
        end else begin
          m = mem_q.pop_front();
          chk("mem_we", 32'(mem_we), 32'(m.we));
          chk("mem_addr", 32'(mem_addr), 32'(m.a));
          if (m.we) chk("mem_wdata", 32'(mem_wdata), 32'(m.d));
        end
      end
      prev_dwe = c_dwe;
      prev_rst = rst;
    end
    chk("sim_done", 32'(done), 32'h1);
    chk("req_timeouts", 32'(to_cnt), 32'h0);
    chk("resp_left", 32'(resp_q.size()), 32'h0);
    chk("dwe_left", 32'(dwe_q.size()), 32'h0);
    chk("mem_left", 32'(mem_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning CPU/memory byte-address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning data word width.
REQ-003 SHALL have ports `clk` (input, 1, rising-edge clock) and `rst` (input, 1); reset rst is synchronous, active-low.
REQ-004 SHALL have ports `cpu_rd` (input, 1, load request) and `cpu_wr` (input, 1, store request).
REQ-005 SHALL have ports `cpu_addr` (input, ADDR_W, request address) and `cpu_wdata` (input, DATA_W, store data).
REQ-006 SHALL have ports `cpu_rdata` (output, DATA_W, load result) and `stall` (output, 1, freeze pipeline).
REQ-007 SHALL have ports `c_hit` (input, 1, cache hit) and `c_rdata` (input, DATA_W, cache read data).
REQ-008 SHALL have ports `c_raddr` and `c_waddr` (outputs, ADDR_W each, cache lookup and fill addresses).
REQ-009 SHALL have ports `c_wdata` (output, DATA_W, cache fill data) and `c_dwe` (output, 1, fill strobe; cache writes on its rising edge).
REQ-010 SHALL have ports `mem_req` (output, 1), `mem_we` (output, 1), `mem_addr` (output, ADDR_W), `mem_wdata` (output, DATA_W), `mem_rdata` (input, DATA_W) and `mem_ack` (input, 1, one-cycle completion).

Function
REQ-011 SHALL drive `c_raddr` = `cpu_addr` combinationally at all times.
REQ-012 SHALL use FSM states IDLE, RD_REQ, FILL, RESP and WR_REQ.
REQ-013 IDLE, `cpu_rd`, `c_hit`=1: `cpu_rdata` = `c_rdata` combinationally, `stall`=0, zero added latency.
REQ-014 IDLE, `cpu_rd`, `c_hit`=0: `stall`=1 in the same cycle; latch `cpu_addr`; go to RD_REQ.
REQ-015 RD_REQ: `mem_req`=1, `mem_we`=0, `mem_addr`=latched address, held stable until `mem_ack`.
REQ-016 RD_REQ on `mem_ack`: register `mem_rdata`; go to FILL.
REQ-017 FILL: `c_dwe`=1 for exactly one cycle, with `c_waddr`=latched address and `c_wdata`=registered data; go to RESP.
REQ-018 RESP: `stall`=0, `cpu_rdata`=registered data for one cycle; go to IDLE.
REQ-019 Read-miss latency SHALL be (memory ack cycles)+3 cycles from miss detection to `stall` deassertion.
REQ-020 IDLE, `cpu_wr`: latch address and data; pulse `c_dwe` for one cycle (write-allocate, write-through) in the next cycle, concurrently with memory write issue.
REQ-021 Memory write SHALL assert `mem_req`=1 and `mem_we`=1 with address and data held until `mem_ack`.
REQ-022 `cpu_rd` and `cpu_wr` asserted together: store SHALL win and the load SHALL be ignored; the CPU reissues it.
REQ-023 `c_dwe` SHALL be 0 outside FILL and store-fill cycles, and SHALL never stay high two consecutive cycles.
REQ-024 `mem_req` SHALL never drop before `mem_ack`; a `mem_ack` arriving while `mem_req`=0 SHALL be ignored.
REQ-025 `stall` SHALL be 1 in RD_REQ and FILL, and SHALL be 0 in IDLE with no pending miss.

Reset
REQ-026 While `rst`=0 at a clock edge: FSM SHALL go to IDLE; `stall`, `c_dwe`, `mem_req` and `mem_we` SHALL be 0; `cpu_rdata`, `c_wdata`, `mem_wdata`, `c_waddr` and `mem_addr` SHALL be 0.
REQ-027 Reset mid-transaction SHALL abandon the transaction: `mem_req` drops at that edge, and the write buffer (if present) is discarded.

Configuration
REQ-028 Macro CACHE_CTRL_WBUF_EN SHALL control the store buffering feature.
REQ-029 With CACHE_CTRL_WBUF_EN defined: a one-entry posted write buffer SHALL be present, and a store into an empty buffer SHALL cause `stall`=0.
REQ-030 With CACHE_CTRL_WBUF_EN defined: a store while the buffer is full SHALL stall until the buffer drains.
REQ-031 With CACHE_CTRL_WBUF_EN defined: a read miss while the buffer is full SHALL wait until the buffer drains before entering RD_REQ, preserving order.
REQ-032 With CACHE_CTRL_WBUF_EN defined: a read hit SHALL proceed unstalled.
REQ-033 Without CACHE_CTRL_WBUF_EN: a store SHALL enter WR_REQ with `stall`=1 until `mem_ack`, then return to IDLE with `stall`=0.

Verification
REQ-034 Hit: `cpu_rd`, addr 0x14, `c_hit`=1, `c_rdata`=0xBEEF -> `cpu_rdata`=0xBEEF and `stall`=0 in the same cycle, with no `mem_req`.
REQ-035 Miss: addr 0x21, `c_hit`=0, `mem_ack` 4 cycles after `mem_req`, `mem_rdata`=0x1234 -> one `c_dwe` pulse with `c_waddr`=0x21 and `c_wdata`=0x1234, then `cpu_rdata`=0x1234 and `stall` low 7 cycles after request.
REQ-036 Store without WBUF: addr 0x08, data 0x00FF, ack after 2 cycles -> `mem_we`=1, `mem_addr`=0x08, one `c_dwe`, `stall`=1 until the ack cycle.
REQ-037 Store with WBUF, then a read miss to 0x30 next cycle -> store `stall`=0, read `mem_req` issued only after the write ack, and memory order is write then read.
REQ-038 Reset asserted in RD_REQ before ack -> `mem_req`=0 and `stall`=0 after that edge, and a late `mem_ack` causes no `c_dwe`.
REQ-039 `cpu_rd`=`cpu_wr`=1 at addr 0x05 -> only a memory write occurs (`mem_we`=1) and no read request is issued.
